// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, operands consumed LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_sum;
  logic             w_carry_next;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_shift;

  assign w_sum        = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_carry_next = (r_a_sr[0] & r_b_sr[0]) | ((r_a_sr[0] ^ r_b_sr[0]) & r_carry);
  assign w_last       = (r_count == CW'(WIDTH - 1));
  assign w_accept     = (r_state == S_IDLE) && start;
  // Newest sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_res_shift  = {w_sum, r_res_sr};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
      r_a_sr  <= a;
      r_b_sr  <= sub ? ~b : b;
      r_carry <= sub;
      r_count <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_carry  <= w_carry_next;
      r_res_sr <= w_res_shift[WIDTH-1:1];
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_result <= w_res_shift;
        r_cout   <= w_carry_next;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_overflow;

  // On the last SHIFT cycle r_carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) r_overflow <= 1'b0;
    else if (r_state == S_SHIFT && w_last) r_overflow <= r_carry ^ w_carry_next;
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  assign result = r_result;
  assign cout   = r_cout;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8).
// Overflow expectations follow whether SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  int tests = 0;
  int fails = 0;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launches one operation, optionally injects a stray start at SHIFT cycle
  // inject_at (a=1, sub=1), and checks latency, busy length and outputs.
  task automatic run_op(input string tag, input int av, input int bv, input logic sv,
                        input int exp_res, input logic exp_cout, input logic exp_ovf,
                        input int inject_at);
    int n;
    int busy_cnt;
    int both;
    @(negedge clk);
    a = WIDTH'(av); b = WIDTH'(bv); sub = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; busy_cnt = 0; both = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (n == inject_at) begin
        a = 8'd1; sub = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (busy && done) both++;
    end
    start = 1'b0;
    check({tag, " latency"}, n, WIDTH);
    check({tag, " busy_cycles"}, busy_cnt, WIDTH);
    check({tag, " busy_and_done"}, both, 0);
    check({tag, " result"}, int'(result), exp_res);
    check({tag, " cout"}, int'(cout), int'(exp_cout));
    check({tag, " overflow"}, int'(overflow), int'(exp_ovf));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " result_held"}, int'(result), exp_res);
    $display("[TB] %s: a=%0d b=%0d sub=%0d -> result=%0d cout=%0d ovf=%0d",
             tag, av, bv, sv, result, cout, overflow);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset cout", int'(cout), 0);
    check("reset overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_100_27", 100, 27, 1'b0, 127, 1'b0, 1'b0, -1);
    run_op("add_200_100", 200, 100, 1'b0, 44, 1'b1, 1'b0, -1);
    run_op("sub_5_3", 5, 3, 1'b1, 2, 1'b1, 1'b0, -1);
    run_op("sub_3_5", 3, 5, 1'b1, 254, 1'b0, 1'b0, -1);
    run_op("add_127_1", 127, 1, 1'b0, 128, 1'b0, OVF_ON, -1);
    run_op("sub_128_1", 128, 1, 1'b1, 127, 1'b1, OVF_ON, -1);
    run_op("ignored_start", 9, 9, 1'b0, 18, 1'b0, 1'b0, 2);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'd50; b = 8'd20; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset result", int'(result), 0);
    check("midreset cout", int'(cout), 0);
    check("midreset overflow", int'(overflow), 0);
    $display("[TB] midreset: busy=%0d done=%0d result=%0d", busy, done, result);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 10, 20, 1'b0, 30, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
